// File: rtl/branch_target_predictor_if.sv
// ============================================================================
// Module   : branch_target_predictor_if
// Purpose  : Fetch lookup and execute-stage training bundle of the predictor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_target_predictor_if;
    logic [15:0] next_program_counter_if_to_bp;
    logic [15:0] target_bp;
    logic        target_en_bp;
    logic        update_en;
    logic [15:0] update_pc;
    logic        update_taken;
    logic [15:0] update_target;
    logic        update_pred_taken;

    modport master (
        output next_program_counter_if_to_bp,
        output update_en,
        output update_pc,
        output update_taken,
        output update_target,
        output update_pred_taken,
        input  target_bp,
        input  target_en_bp
    );

    modport slave (
        input  next_program_counter_if_to_bp,
        input  update_en,
        input  update_pc,
        input  update_taken,
        input  update_target,
        input  update_pred_taken,
        output target_bp,
        output target_en_bp
    );
endinterface

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// ============================================================================
// Module   : branch_target_predictor
// Purpose  : Direct-mapped BTB with 2-bit direction counters; combinational
//            lookup, registered training. Optional macro BP_STATS_EN adds
//            saturating update/mispredict/hit counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_predictor #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    branch_target_predictor_if.slave      bp
`ifdef BP_STATS_EN
    ,
    output logic [15:0]                   stat_updates,
    output logic [15:0]                   stat_mispredicts,
    output logic [15:0]                   stat_hits
`endif
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 16 - IDX_W;

    logic             valid_tbl  [ENTRIES];
    logic [TAG_W-1:0] tag_tbl    [ENTRIES];
    logic [15:0]      target_tbl [ENTRIES];
    logic [1:0]       ctr_tbl    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             pred_en;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    assign lk_idx = bp.next_program_counter_if_to_bp[IDX_W-1:0];
    assign lk_tag = bp.next_program_counter_if_to_bp[15:IDX_W];
    assign up_idx = bp.update_pc[IDX_W-1:0];
    assign up_tag = bp.update_pc[15:IDX_W];

    always_comb begin
        lk_hit = valid_tbl[lk_idx] && (tag_tbl[lk_idx] == lk_tag);
        up_hit = valid_tbl[up_idx] && (tag_tbl[up_idx] == up_tag);
    end

    // Outputs are forced quiet while reset is held, whatever the table holds.
    assign pred_en         = rst_n && lk_hit && ctr_tbl[lk_idx][1];
    assign bp.target_en_bp = pred_en;
    assign bp.target_bp    = (rst_n && lk_hit) ? target_tbl[lk_idx] : 16'h0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_tbl[i] <= 1'b0;
                ctr_tbl[i]   <= 2'b01;
            end
        end else if (bp.update_en) begin
            if (up_hit) begin
                ctr_tbl[up_idx] <= bp.update_taken ? sat_inc(ctr_tbl[up_idx])
                                                   : sat_dec(ctr_tbl[up_idx]);
            end else if (bp.update_taken) begin
                valid_tbl[up_idx] <= 1'b1;
                ctr_tbl[up_idx]   <= CTR_INIT;
            end
        end
    end

    // Tag and target carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (rst_n && bp.update_en && bp.update_taken) begin
            target_tbl[up_idx] <= bp.update_target;
            if (!up_hit) begin
                tag_tbl[up_idx] <= up_tag;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_updates     <= 16'h0000;
            stat_mispredicts <= 16'h0000;
            stat_hits        <= 16'h0000;
        end else begin
            if (bp.update_en && stat_updates != 16'hFFFF) begin
                stat_updates <= stat_updates + 16'd1;
            end
            if (bp.update_en && (bp.update_pred_taken != bp.update_taken)
                && stat_mispredicts != 16'hFFFF) begin
                stat_mispredicts <= stat_mispredicts + 16'd1;
            end
            if (pred_en && stat_hits != 16'hFFFF) begin
                stat_hits <= stat_hits + 16'd1;
            end
        end
    end
`else
    logic unused_pred_taken;
    assign unused_pred_taken = bp.update_pred_taken;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// ============================================================================
// Module   : tb_branch_target_predictor
// Purpose  : Directed self-checking bench for branch_target_predictor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_predictor;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    branch_target_predictor_if bp_if ();

`ifdef BP_STATS_EN
    logic [15:0] stat_updates;
    logic [15:0] stat_mispredicts;
    logic [15:0] stat_hits;
`endif

    branch_target_predictor #(
        .IDX_W    (4),
        .CTR_INIT (2'b10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
`ifdef BP_STATS_EN
        ,
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts),
        .stat_hits        (stat_hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [15:0] pc, input logic taken,
                             input logic [15:0] tgt, input logic pred);
        bp_if.update_en         = 1'b1;
        bp_if.update_pc         = pc;
        bp_if.update_taken      = taken;
        bp_if.update_target     = tgt;
        bp_if.update_pred_taken = pred;
        tick();
        bp_if.update_en = 1'b0;
    endtask

    // Applies a lookup PC and compares {enable, target} in mid-cycle.
    task automatic look(input string name, input logic [15:0] pc,
                        input logic exp_en, input logic [15:0] exp_tgt);
        bp_if.next_program_counter_if_to_bp = pc;
        #1;
        vectors++;
        if ({bp_if.target_en_bp, bp_if.target_bp} !== {exp_en, exp_tgt}) begin
            miscompares++;
            $display("FAIL %s pc=%h: got en=%b tgt=%h, expected en=%b tgt=%h",
                     name, pc, bp_if.target_en_bp, bp_if.target_bp, exp_en, exp_tgt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bp_if.update_en = 1'b0;
        tick();
        tick();
        look("reset_held", 16'h0013, 1'b0, 16'h0000);
        rst_n = 1'b1;
        tick();
        for (int p = 0; p < 256; p++) begin
            look("reset_clear", 16'(p), 1'b0, 16'h0000);
        end
    endtask

    task automatic test_allocate();
        do_update(16'h0013, 1'b1, 16'h0040, 1'b0);
        look("alloc_hit", 16'h0013, 1'b1, 16'h0040);
        look("alloc_alias_miss", 16'h0023, 1'b0, 16'h0000);
        do_update(16'h0031, 1'b0, 16'h0099, 1'b0);
        look("no_alloc_not_taken", 16'h0031, 1'b0, 16'h0000);
    endtask

    task automatic test_hysteresis();
        do_update(16'h0013, 1'b0, 16'h0000, 1'b1);
        look("hyst_nt1", 16'h0013, 1'b0, 16'h0040);
        do_update(16'h0013, 1'b0, 16'h0000, 1'b0);
        look("hyst_nt2", 16'h0013, 1'b0, 16'h0040);
        do_update(16'h0013, 1'b1, 16'h0040, 1'b0);
        look("hyst_t1", 16'h0013, 1'b0, 16'h0040);
        do_update(16'h0013, 1'b1, 16'h0040, 1'b0);
        look("hyst_t2", 16'h0013, 1'b1, 16'h0040);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            do_update(16'h0013, 1'b1, 16'h0040, 1'b1);
        end
        do_update(16'h0013, 1'b1, 16'h0044, 1'b1);
        look("sat_taken", 16'h0013, 1'b1, 16'h0044);
        do_update(16'h0013, 1'b0, 16'h0000, 1'b1);
        look("sat_one_nt", 16'h0013, 1'b1, 16'h0044);
        do_update(16'h0013, 1'b0, 16'h0000, 1'b1);
        look("sat_two_nt", 16'h0013, 1'b0, 16'h0044);
        do_update(16'h0013, 1'b1, 16'h0044, 1'b0);
        do_update(16'h0013, 1'b1, 16'h0044, 1'b0);
    endtask

    task automatic test_back_to_back();
        bp_if.update_en         = 1'b1;
        bp_if.update_pc         = 16'h0005;
        bp_if.update_taken      = 1'b1;
        bp_if.update_target     = 16'h0077;
        bp_if.update_pred_taken = 1'b0;
        look("same_cycle_pre", 16'h0005, 1'b0, 16'h0000);
        tick();
        bp_if.update_en = 1'b0;
        look("same_cycle_post", 16'h0005, 1'b1, 16'h0077);
    endtask

    task automatic test_alias_evict();
        do_update(16'h0023, 1'b1, 16'h0088, 1'b0);
        look("evict_new", 16'h0023, 1'b1, 16'h0088);
        look("evict_old", 16'h0013, 1'b0, 16'h0000);
        look("evict_other_idx", 16'h0005, 1'b1, 16'h0077);
    endtask

    task automatic test_reset_midrun();
        rst_n                   = 1'b0;
        bp_if.update_en         = 1'b1;
        bp_if.update_pc         = 16'h0099;
        bp_if.update_taken      = 1'b1;
        bp_if.update_target     = 16'h0011;
        look("midrst_held", 16'h0005, 1'b0, 16'h0000);
        tick();
        tick();
        rst_n           = 1'b1;
        bp_if.update_en = 1'b0;
        look("midrst_a", 16'h0005, 1'b0, 16'h0000);
        look("midrst_b", 16'h0023, 1'b0, 16'h0000);
        look("midrst_c", 16'h0099, 1'b0, 16'h0000);
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        bp_if.next_program_counter_if_to_bp = 16'h00FF;
        vectors++;
        if ({stat_updates, stat_mispredicts, stat_hits} !== 48'h0) begin
            miscompares++;
            $display("FAIL stats_after_reset: got %h %h %h, expected 0 0 0",
                     stat_updates, stat_mispredicts, stat_hits);
        end
        do_update(16'h0042, 1'b0, 16'h0000, 1'b0);
        do_update(16'h0042, 1'b0, 16'h0000, 1'b0);
        do_update(16'h0042, 1'b0, 16'h0000, 1'b1);
        vectors++;
        if ({stat_updates, stat_mispredicts, stat_hits} !== {16'd3, 16'd1, 16'd0}) begin
            miscompares++;
            $display("FAIL stats_count: got %h %h %h, expected 0003 0001 0000",
                     stat_updates, stat_mispredicts, stat_hits);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({stat_updates, stat_mispredicts, stat_hits} !== 48'h0) begin
            miscompares++;
            $display("FAIL stats_clear: got %h %h %h, expected 0 0 0",
                     stat_updates, stat_mispredicts, stat_hits);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n                               = 1'b0;
        bp_if.next_program_counter_if_to_bp = 16'h0000;
        bp_if.update_en                     = 1'b0;
        bp_if.update_pc                     = 16'h0000;
        bp_if.update_taken                  = 1'b0;
        bp_if.update_target                 = 16'h0000;
        bp_if.update_pred_taken             = 1'b0;
        test_reset();
        test_allocate();
        test_hysteresis();
        test_saturation();
        test_back_to_back();
        test_alias_evict();
        test_reset_midrun();
`ifdef BP_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
